// File: rtl/sad_scan_controller.sv
// sad_scan_controller: raster-scans every template window of the frame,
// strobes the PE array, and tracks the minimum-SAD window position.
// Ports: i_clock, i_reset_n (async, active-low), i_start, i_ram_ready,
//   i_pe_sad in; o_ram_addr, o_rom_addr, o_win_x, o_pe_reset, o_pe_shift,
//   o_pe_match, o_busy, o_valid, o_x_out, o_y_out, o_best_sad out.
// Option: SAD_EARLY_EXIT_EN ends the scan on the first zero-SAD window.
module sad_scan_controller #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int TPL   = 8,
  parameter int SAD_W = 16
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_ram_ready,
  input  logic [SAD_W-1:0] i_pe_sad,
  output logic [8:0]       o_ram_addr,
  output logic [11:0]      o_rom_addr,
  output logic [9:0]       o_win_x,
  output logic             o_pe_reset,
  output logic             o_pe_shift,
  output logic             o_pe_match,
  output logic             o_busy,
  output logic             o_valid,
  output logic [9:0]       o_x_out,
  output logic [8:0]       o_y_out,
  output logic [SAD_W-1:0] o_best_sad
);

  localparam int KW = (TPL > 1) ? $clog2(TPL) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(TPL - 1);
  localparam logic [9:0]    X_LAST = 10'(IMG_W - TPL);
  localparam logic [8:0]    Y_LAST = 9'(IMG_H - TPL);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_PRST, S_SHIFT, S_MATCH, S_CMP, S_DONE
  } state_t;

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic [9:0]       r_x_pos;
  logic [8:0]       r_y_pos;
  logic [8:0]       r_ram_addr;
  logic [11:0]      r_rom_addr;
  logic             r_pe_reset;
  logic             r_pe_shift;
  logic             r_pe_match;
  logic             r_busy;
  logic             r_valid;
  logic [9:0]       r_x_out;
  logic [8:0]       r_y_out;
  logic [SAD_W-1:0] r_best;

  logic w_last;
  logic w_zero;
  logic w_better;

  assign w_last   = (r_x_pos == X_LAST) && (r_y_pos == Y_LAST);
  assign w_better = (i_pe_sad < r_best);
`ifdef SAD_EARLY_EXIT_EN
  assign w_zero = (i_pe_sad == '0);
`else
  assign w_zero = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_x_pos    <= '0;
      r_y_pos    <= '0;
      r_ram_addr <= '0;
      r_rom_addr <= '0;
      r_pe_reset <= 1'b0;
      r_pe_shift <= 1'b0;
      r_pe_match <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_x_out    <= '0;
      r_y_out    <= '0;
      r_best     <= '1;
    end else begin
      r_pe_reset <= 1'b0;
      r_pe_shift <= 1'b0;
      r_pe_match <= 1'b0;
      r_valid    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_WAIT;
            r_busy  <= 1'b1;
            r_x_pos <= '0;
            r_y_pos <= '0;
            r_best  <= '1;
            r_x_out <= '0;
            r_y_out <= '0;
          end
        end
        S_WAIT: begin
          if (i_ram_ready) begin
            r_state    <= S_PRST;
            r_pe_reset <= 1'b1;
            r_k        <= '0;
          end
        end
        S_PRST: begin
          r_state    <= S_SHIFT;
          r_pe_shift <= 1'b1;
          r_k        <= '0;
          r_ram_addr <= r_y_pos;
          r_rom_addr <= '0;
        end
        S_SHIFT: begin
          if (r_k == K_LAST) begin
            r_state    <= S_MATCH;
            r_pe_match <= 1'b1;
          end else begin
            r_pe_shift <= 1'b1;
            r_k        <= r_k + 1'b1;
            r_ram_addr <= r_y_pos + 9'(r_k) + 9'd1;
            r_rom_addr <= 12'(r_k) + 12'd1;
          end
        end
        S_MATCH: begin
          r_state <= S_CMP;
        end
        S_CMP: begin
          if (w_better) begin
            r_best  <= i_pe_sad;
            r_x_out <= r_x_pos;
            r_y_out <= r_y_pos;
          end
          if (w_last || w_zero) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state    <= S_PRST;
            r_pe_reset <= 1'b1;
            r_k        <= '0;
          end
          // A perfect match keeps the position of the window that ended the scan.
          if (!w_zero) begin
            if (r_x_pos == X_LAST) begin
              r_x_pos <= '0;
              if (!w_last) r_y_pos <= r_y_pos + 9'd1;
            end else begin
              r_x_pos <= r_x_pos + 10'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ram_addr = r_ram_addr;
  assign o_rom_addr = r_rom_addr;
  assign o_win_x    = r_x_pos;
  assign o_pe_reset = r_pe_reset;
  assign o_pe_shift = r_pe_shift;
  assign o_pe_match = r_pe_match;
  assign o_busy     = r_busy;
  assign o_valid    = r_valid;
  assign o_x_out    = r_x_out;
  assign o_y_out    = r_y_out;
  assign o_best_sad = r_best;

endmodule

// File: tb/tb_sad_scan_controller.sv
// tb_sad_scan_controller: randomized scans of a 12x10 frame with a 4x4
// template, checked every cycle against a window-timeline model.
`timescale 1ns/1ps
module tb_sad_scan_controller;

  localparam int IMG_W = 12;
  localparam int IMG_H = 10;
  localparam int TPL   = 4;
  localparam int SAD_W = 16;
  localparam int XW    = IMG_W - TPL + 1;
  localparam int YW    = IMG_H - TPL + 1;
  localparam int NWIN  = XW * YW;
  localparam int PER   = TPL + 3;
`ifdef SAD_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             ram_ready = 1'b0;
  logic [SAD_W-1:0] pe_sad = '0;
  logic [8:0]       ram_addr;
  logic [11:0]      rom_addr;
  logic [9:0]       win_x;
  logic             pe_reset, pe_shift, pe_match;
  logic             busy, valid;
  logic [9:0]       x_out;
  logic [8:0]       y_out;
  logic [SAD_W-1:0] best_sad;

  sad_scan_controller #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .TPL(TPL), .SAD_W(SAD_W)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start),
    .i_ram_ready(ram_ready), .i_pe_sad(pe_sad),
    .o_ram_addr(ram_addr), .o_rom_addr(rom_addr), .o_win_x(win_x),
    .o_pe_reset(pe_reset), .o_pe_shift(pe_shift), .o_pe_match(pe_match),
    .o_busy(busy), .o_valid(valid), .o_x_out(x_out), .o_y_out(y_out),
    .o_best_sad(best_sad)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  logic [SAD_W-1:0] sad_tab [NWIN];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 waiting for RAM, 2 scanning (m_c = scan cycle), 3 done.
  int               m_mode = 0;
  int               m_c = 0;
  logic [SAD_W-1:0] m_best = '1;
  int               m_bx = 0;
  int               m_by = 0;
  logic [8:0]       m_ram = '0;
  logic [11:0]      m_rom = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_c = 0; m_best = '1; m_bx = 0; m_by = 0;
      m_ram = '0; m_rom = '0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_mode = 1; m_best = '1; m_bx = 0; m_by = 0;
        end
        1: if (ram_ready) begin
          m_mode = 2; m_c = 0;
        end
        2: begin
          if (m_c % PER == PER - 1) begin
            int w;
            w = m_c / PER;
            if (pe_sad < m_best) begin
              m_best = pe_sad; m_bx = w % XW; m_by = w / XW;
            end
            if (w == NWIN - 1 || (EARLY && pe_sad == 0)) m_mode = 3;
            else m_c++;
          end else begin
            m_c++;
          end
        end
        default: m_mode = 0;
      endcase
      if (m_mode == 2 && m_c % PER >= 1 && m_c % PER <= TPL) begin
        m_ram = 9'(((m_c / PER) / XW + m_c % PER - 1) % 512);
        m_rom = 12'(m_c % PER - 1);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit sc;
      int ph;
      sc = (m_mode == 2);
      ph = m_c % PER;
      chk("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
      chk("valid", 32'(valid), 32'(m_mode == 3));
      chk("pe_reset", 32'(pe_reset), 32'(sc && ph == 0));
      chk("pe_shift", 32'(pe_shift), 32'(sc && ph >= 1 && ph <= TPL));
      chk("pe_match", 32'(pe_match), 32'(sc && ph == TPL + 1));
      chk("ram_addr", 32'(ram_addr), 32'(m_ram));
      chk("rom_addr", 32'(rom_addr), 32'(m_rom));
      chk("x_out", 32'(x_out), 32'(m_bx));
      chk("y_out", 32'(y_out), 32'(m_by));
      chk("best_sad", 32'(best_sad), 32'(m_best));
      if (m_mode == 1) chk("win_x", 32'(win_x), 32'd0);
      if (sc) chk("win_x", 32'(win_x), 32'((m_c / PER) % XW));
    end
  end

  task automatic drive_cycle(input bit noise);
    @(posedge clk);
    #1;
    start = 1'b0;
    ram_ready = 1'b0;
    pe_sad = (m_mode == 2) ? sad_tab[m_c / PER] : 16'($urandom);
    if (noise && m_mode == 2) begin
      start = ($urandom_range(0, 3) == 0);
      ram_ready = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic run_scan(input int dly, input bit noise, input bit addr_chk,
                          input int exp_len);
    int first_prst, vcyc, vcnt, nsh;
    bit done;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (dly - 1) @(posedge clk);
    #1 ram_ready = 1'b1;
    first_prst = -1; vcyc = -1; vcnt = 0; nsh = 0; done = 1'b0;
    for (int c = 0; c < 1200 && !done; c++) begin
      @(negedge clk);
      if (pe_reset && first_prst < 0) first_prst = c;
      if (pe_shift) begin
        if (addr_chk && nsh < 4) begin
          chk("win0_ram_addr", 32'(ram_addr), 32'(nsh));
          chk("win0_rom_addr", 32'(rom_addr), 32'(nsh));
        end
        if (addr_chk && nsh >= 72 && nsh < 76) begin
          chk("y2_ram_addr", 32'(ram_addr), 32'(nsh - 70));
          chk("y2_rom_addr", 32'(rom_addr), 32'(nsh - 72));
        end
        nsh++;
      end
      if (valid) begin
        vcnt++;
        if (vcyc < 0) vcyc = c;
      end
      if (vcyc >= 0 && c >= vcyc + 3) done = 1'b1;
      if (!done) drive_cycle(noise);
    end
    if (vcyc < 0) $display("FAIL scan_timeout: got no valid expected one");
    chk("valid_count", 32'(vcnt), 32'd1);
    chk("scan_len", 32'(vcyc - first_prst), 32'(exp_len));
  endtask

  task automatic reset_mid_shift();
    int guard;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 ram_ready = 1'b1;
    guard = 0;
    while (!(m_mode == 2 && m_c == PER + 2) && guard < 100) begin
      drive_cycle(1'b0);
      guard++;
    end
    chk("reached_shift", 32'(pe_shift), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_shift", 32'(pe_shift), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_win_x", 32'(win_x), 32'd0);
    chk("rst_best", 32'(best_sad), 32'hFFFF);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) drive_cycle(1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("init_best", 32'(best_sad), 32'hFFFF);
    chk("init_valid", 32'(valid), 32'd0);
    rst_n = 1'b1;
    repeat (2) drive_cycle(1'b0);

    for (int i = 0; i < NWIN; i++) sad_tab[i] = 16'd100;
    sad_tab[3 * XW + 5] = 16'd7;
    run_scan(5, 1'b0, 1'b1, 441);
    chk("A_x", 32'(x_out), 32'd5);
    chk("A_y", 32'(y_out), 32'd3);
    chk("A_sad", 32'(best_sad), 32'd7);

    for (int i = 0; i < NWIN; i++) sad_tab[i] = 16'd80;
    sad_tab[1 * XW + 2] = 16'd50;
    sad_tab[4 * XW + 6] = 16'd50;
    run_scan(3, 1'b1, 1'b0, 441);
    chk("B_x", 32'(x_out), 32'd2);
    chk("B_y", 32'(y_out), 32'd1);
    chk("B_sad", 32'(best_sad), 32'd50);

    reset_mid_shift();

    for (int i = 0; i < NWIN; i++) sad_tab[i] = 16'($urandom_range(1, 255));
    run_scan(int'($urandom_range(1, 6)), 1'b1, 1'b1, 441);

    for (int i = 0; i < NWIN; i++) sad_tab[i] = 16'($urandom_range(1, 500));
    sad_tab[1] = 16'd0;
    run_scan(2, 1'b1, 1'b0, EARLY ? 14 : 441);
    chk("E_x", 32'(x_out), 32'd1);
    chk("E_y", 32'(y_out), 32'd0);
    chk("E_sad", 32'(best_sad), 32'd0);

    for (int i = 0; i < NWIN; i++) sad_tab[i] = 16'hFFFF;
    run_scan(1, 1'b0, 1'b0, 441);
    chk("F_x", 32'(x_out), 32'd0);
    chk("F_y", 32'(y_out), 32'd0);
    chk("F_sad", 32'(best_sad), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
